// File: rtl/mult_share_pkg.sv
// Shared types and widths for the multiplier-sharing scheduler.
package mult_share_pkg;

    localparam int unsigned OPND_W = 4;
    localparam int unsigned PROD_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        RESP = 2'd2
    } mult_share_state_t;

endpackage

// File: rtl/array_multiplier_4bit.sv
// Combinational unsigned 4x4 array multiplier (shift-and-add of partial products).
module array_multiplier_4bit
    import mult_share_pkg::*;
(
    input  logic [OPND_W-1:0] a,
    input  logic [OPND_W-1:0] b,
    output logic [PROD_W-1:0] p
);

    always_comb begin
        p = '0;
        for (int i = 0; i < int'(OPND_W); i++) begin
            if (b[i]) begin
                p = p + (PROD_W'(a) << i);
            end
        end
    end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: first asserted request at or after ptr, scanning upward with wrap.
module rr_arbiter #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned ID_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [ID_W-1:0] ptr,
    output logic [NREQ-1:0] gnt,
    output logic [ID_W-1:0] idx,
    output logic            any
);

    int j;

    // Scan farthest offset first so the nearest request to ptr wins last.
    always_comb begin
        idx = '0;
        any = 1'b0;
        j   = 0;
        for (int k = int'(NREQ) - 1; k >= 0; k--) begin
            j = (int'(ptr) + k) % int'(NREQ);
            if (req[j]) begin
                idx = ID_W'(j);
                any = 1'b1;
            end
        end
        gnt = any ? (NREQ'(1) << idx) : '0;
    end

endmodule

// File: rtl/mult_share_ctrl.sv
// Round-robin scheduler sharing one 4x4 multiplier among NREQ requesters,
// returning the product and owner id over a single valid/ready response.
module mult_share_ctrl
    import mult_share_pkg::*;
#(
    parameter int unsigned NREQ = 4,
    parameter int unsigned ID_W = $clog2(NREQ)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NREQ-1:0]          req_valid,
    output logic [NREQ-1:0]          req_ready,
    input  logic [NREQ*OPND_W-1:0]   req_a,
    input  logic [NREQ*OPND_W-1:0]   req_b,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [PROD_W-1:0]        rsp_data,
    output logic [ID_W-1:0]          rsp_id,
    output logic                     busy
);

    mult_share_state_t state_q, state_d;

    logic [ID_W-1:0]   rr_ptr, id_q, arb_idx, ptr_nxt;
    logic [NREQ-1:0]   arb_gnt;
    logic              arb_any;
    logic [OPND_W-1:0] a_q, b_q, sel_a, sel_b;
    logic [PROD_W-1:0] prod;
    logic              accept, load_rsp;

    rr_arbiter #(
        .NREQ (NREQ),
        .ID_W (ID_W)
    ) u_arb (
        .req  (req_valid),
        .ptr  (rr_ptr),
        .gnt  (arb_gnt),
        .idx  (arb_idx),
        .any  (arb_any)
    );

    array_multiplier_4bit u_mul (
        .a (a_q),
        .b (b_q),
        .p (prod)
    );

    // Operand mux for the arbitration winner.
    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int i = 0; i < int'(NREQ); i++) begin
            if (ID_W'(i) == arb_idx) begin
                sel_a = req_a[i*OPND_W +: OPND_W];
                sel_b = req_b[i*OPND_W +: OPND_W];
            end
        end
    end

    // Pointer advances past the winner; explicit wrap keeps it below NREQ.
    assign ptr_nxt = (arb_idx == ID_W'(NREQ - 1)) ? '0 : arb_idx + ID_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        req_ready = '0;
        accept    = 1'b0;
        load_rsp  = 1'b0;
        case (state_q)
            IDLE: begin
                req_ready = arb_gnt;
                if (arb_any) begin
                    accept  = 1'b1;
                    state_d = MUL;
                end
            end
            MUL: begin
                load_rsp = 1'b1;
                state_d  = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Datapath and status flops; status follows the next state so it lines up with state_q.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q       <= '0;
            b_q       <= '0;
            id_q      <= '0;
            rr_ptr    <= '0;
            rsp_data  <= '0;
            rsp_id    <= '0;
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            if (accept) begin
                a_q    <= sel_a;
                b_q    <= sel_b;
                id_q   <= arb_idx;
                rr_ptr <= ptr_nxt;
            end
            if (load_rsp) begin
                rsp_data <= prod;
                rsp_id   <= id_q;
            end
            rsp_valid <= (state_d == RESP);
            busy      <= (state_d != IDLE);
        end
    end

endmodule

// File: tb/tb_mult_share_ctrl.sv
// Self-checking bench for mult_share_ctrl against a round-robin/product reference model.
module tb_mult_share_ctrl;

    localparam int unsigned NREQ = 4;
    localparam int unsigned ID_W = 2;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ*4-1:0]    req_a;
    logic [NREQ*4-1:0]    req_b;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [7:0]           rsp_data;
    logic [ID_W-1:0]      rsp_id;
    logic                 busy;

    int checks = 0;
    int errors = 0;
    int m_ptr  = 0;

    mult_share_ctrl #(.NREQ(NREQ)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_id    (rsp_id),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Reference arbitration rule: first valid requester at or after ptr, with wrap.
    function automatic int pick(input logic [NREQ-1:0] v, input int ptr);
        for (int k = 0; k < int'(NREQ); k++) begin
            if (v[(ptr + k) % int'(NREQ)]) return (ptr + k) % int'(NREQ);
        end
        return -1;
    endfunction

    function automatic logic [NREQ-1:0] onehot(input int w);
        return (w < 0) ? '0 : NREQ'(1) << w;
    endfunction

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int i, input int a, input int b);
        req_a[i*4 +: 4] = 4'(a);
        req_b[i*4 +: 4] = 4'(b);
    endtask

    task automatic do_reset;
        rst_n     = 1'b0;
        req_valid = '0;
        rsp_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        m_ptr = 0;
    endtask

    task automatic test_reset;
        rst_n     = 1'b0;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b0;
        #1;
        checks++;
        if (req_ready !== '0 || rsp_valid !== 1'b0 || busy !== 1'b0 ||
            rsp_data !== 8'd0 || rsp_id !== '0) begin
            errors++;
            $display("FAIL reset_outputs ready=%b valid=%b busy=%b data=%0d id=%0d required all 0",
                     req_ready, rsp_valid, busy, rsp_data, rsp_id);
        end
        do_reset();
        checks++;
        if (busy !== 1'b0 || rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_release busy=%b valid=%b required 0 0", busy, rsp_valid);
        end
    endtask

    task automatic test_single;
        int w;
        set_op(2, 15, 15);
        rsp_ready = 1'b1;
        req_valid = 4'b0100;
        #1;
        w = pick(req_valid, m_ptr);
        checks++;
        if (req_ready !== onehot(w)) begin
            errors++;
            $display("FAIL single_grant got %b required %b", req_ready, onehot(w));
        end
        m_ptr = (w + 1) % int'(NREQ);
        step();
        req_valid = '0;
        checks++;
        if (busy !== 1'b1 || rsp_valid !== 1'b0 || req_ready !== '0) begin
            errors++;
            $display("FAIL single_mul busy=%b valid=%b ready=%b required 1 0 0000", busy, rsp_valid, req_ready);
        end
        step();
        checks++;
        if (rsp_valid !== 1'b1 || rsp_data !== 8'hE1 || rsp_id !== ID_W'(2)) begin
            errors++;
            $display("FAIL single_resp valid=%b data=%0d id=%0d required 1 225 2", rsp_valid, rsp_data, rsp_id);
        end
        step();
        checks++;
        if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL single_done valid=%b busy=%b required 0 0", rsp_valid, busy);
        end
    endtask

    task automatic test_all_four;
        logic [NREQ-1:0] pending;
        int w;
        do_reset();
        for (int i = 0; i < int'(NREQ); i++) set_op(i, i, 3);
        pending   = '1;
        req_valid = pending;
        rsp_ready = 1'b1;
        for (int n = 0; n < int'(NREQ); n++) begin
            #1;
            w = pick(pending, m_ptr);
            checks++;
            if (req_ready !== onehot(w) || w != n) begin
                errors++;
                $display("FAIL all4_grant n=%0d got %b required %b", n, req_ready, onehot(n));
            end
            m_ptr = (w + 1) % int'(NREQ);
            step();
            pending[w] = 1'b0;
            req_valid  = pending;
            step();
            checks++;
            if (rsp_valid !== 1'b1 || rsp_data !== 8'(w * 3) || rsp_id !== ID_W'(w)) begin
                errors++;
                $display("FAIL all4_resp n=%0d valid=%b data=%0d id=%0d required 1 %0d %0d",
                         n, rsp_valid, rsp_data, rsp_id, w * 3, w);
            end
            step();
        end
    endtask

    task automatic test_wrap;
        int w;
        rsp_ready = 1'b1;
        set_op(2, 2, 2);
        req_valid = 4'b0100;
        #1;
        w = pick(req_valid, m_ptr);
        m_ptr = (w + 1) % int'(NREQ);
        step();
        req_valid = '0;
        step();
        step();
        // Pointer now sits at 3; requesters 3 and 0 compete.
        set_op(3, 3, 5);
        set_op(0, 4, 4);
        req_valid = 4'b1001;
        #1;
        w = pick(req_valid, m_ptr);
        checks++;
        if (req_ready !== onehot(w) || w != 3) begin
            errors++;
            $display("FAIL wrap_first got %b required %b", req_ready, 4'b1000);
        end
        m_ptr = (w + 1) % int'(NREQ);
        step();
        req_valid = 4'b0001;
        step();
        checks++;
        if (rsp_data !== 8'd15 || rsp_id !== ID_W'(3)) begin
            errors++;
            $display("FAIL wrap_first_resp data=%0d id=%0d required 15 3", rsp_data, rsp_id);
        end
        step();
        w = pick(req_valid, m_ptr);
        checks++;
        if (req_ready !== onehot(w) || w != 0) begin
            errors++;
            $display("FAIL wrap_second got %b required %b", req_ready, 4'b0001);
        end
        m_ptr = (w + 1) % int'(NREQ);
        step();
        req_valid = '0;
        step();
        checks++;
        if (rsp_data !== 8'd16 || rsp_id !== ID_W'(0)) begin
            errors++;
            $display("FAIL wrap_second_resp data=%0d id=%0d required 16 0", rsp_data, rsp_id);
        end
        step();
        // Pointer should be 1: requester 1 beats 0. Withdraw before the edge.
        req_valid = 4'b0011;
        #1;
        w = pick(req_valid, m_ptr);
        checks++;
        if (req_ready !== onehot(w) || w != 1) begin
            errors++;
            $display("FAIL wrap_ptr_end got %b required %b", req_ready, 4'b0010);
        end
        req_valid = '0;
        #1;
        checks++;
        if (req_ready !== '0) begin
            errors++;
            $display("FAIL withdraw_ready got %b required 0000", req_ready);
        end
        step();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL withdraw_busy got %b required 0", busy);
        end
    endtask

    task automatic test_backpressure;
        int w;
        for (int i = 0; i < int'(NREQ); i++) set_op(i, 7, 9);
        rsp_ready = 1'b0;
        req_valid = '1;
        #1;
        w = pick(req_valid, m_ptr);
        m_ptr = (w + 1) % int'(NREQ);
        step();
        req_valid = '1 & ~onehot(w);
        step();
        for (int c = 0; c < 5; c++) begin
            checks++;
            if (rsp_valid !== 1'b1 || rsp_data !== 8'd63 || rsp_id !== ID_W'(w) || req_ready !== '0) begin
                errors++;
                $display("FAIL bp_hold c=%0d valid=%b data=%0d id=%0d ready=%b required 1 63 %0d 0000",
                         c, rsp_valid, rsp_data, rsp_id, req_ready, w);
            end
            step();
        end
        rsp_ready = 1'b1;
        #1;
        checks++;
        if (rsp_valid !== 1'b1 || req_ready !== '0) begin
            errors++;
            $display("FAIL bp_accept_cycle valid=%b ready=%b required 1 0000", rsp_valid, req_ready);
        end
        step();
        checks++;
        if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL bp_released valid=%b busy=%b required 0 0", rsp_valid, busy);
        end
        req_valid = '0;
        #1;
    endtask

    task automatic test_reset_mid;
        rsp_ready = 1'b1;
        set_op(1, 5, 5);
        req_valid = 4'b0010;
        step();
        req_valid = '0;
        rst_n     = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || rsp_valid !== 1'b0 || rsp_data !== 8'd0 ||
            rsp_id !== '0 || req_ready !== '0) begin
            errors++;
            $display("FAIL midreset_async busy=%b valid=%b data=%0d id=%0d ready=%b required all 0",
                     busy, rsp_valid, rsp_data, rsp_id, req_ready);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        m_ptr = 0;
        for (int c = 0; c < 4; c++) begin
            checks++;
            if (rsp_valid !== 1'b0 || rsp_data !== 8'd0) begin
                errors++;
                $display("FAIL midreset_dropped c=%0d valid=%b data=%0d required 0 0", c, rsp_valid, rsp_data);
            end
            step();
        end
        req_valid = '1;
        #1;
        checks++;
        if (req_ready !== onehot(pick(req_valid, m_ptr))) begin
            errors++;
            $display("FAIL midreset_ptr got %b required %b", req_ready, 4'b0001);
        end
        req_valid = '0;
        #1;
    endtask

    task automatic test_zero;
        int w;
        int ops_a[2] = '{0, 1};
        int ops_b[2] = '{13, 15};
        rsp_ready = 1'b1;
        for (int n = 0; n < 2; n++) begin
            for (int i = 0; i < int'(NREQ); i++) set_op(i, ops_a[n], ops_b[n]);
            req_valid = '1;
            #1;
            w = pick(req_valid, m_ptr);
            m_ptr = (w + 1) % int'(NREQ);
            step();
            req_valid = '0;
            step();
            checks++;
            if (rsp_valid !== 1'b1 || rsp_data !== 8'(ops_a[n] * ops_b[n]) || rsp_id !== ID_W'(w)) begin
                errors++;
                $display("FAIL zero_op n=%0d valid=%b data=%0d id=%0d required 1 %0d %0d",
                         n, rsp_valid, rsp_data, rsp_id, ops_a[n] * ops_b[n], w);
            end
            step();
        end
    endtask

    task automatic test_random;
        logic [NREQ-1:0] mask;
        int w;
        int waited;
        int av[NREQ];
        int bv[NREQ];
        for (int n = 0; n < 30; n++) begin
            mask = NREQ'($urandom_range(1, (1 << NREQ) - 1));
            for (int i = 0; i < int'(NREQ); i++) begin
                av[i] = int'($urandom_range(0, 15));
                bv[i] = int'($urandom_range(0, 15));
                set_op(i, av[i], bv[i]);
            end
            rsp_ready = 1'b0;
            req_valid = mask;
            #1;
            w = pick(mask, m_ptr);
            checks++;
            if (req_ready !== onehot(w)) begin
                errors++;
                $display("FAIL rand_grant n=%0d got %b required %b", n, req_ready, onehot(w));
            end
            m_ptr = (w + 1) % int'(NREQ);
            step();
            req_valid = '0;
            step();
            waited = 0;
            do begin
                checks++;
                if (rsp_valid !== 1'b1 || rsp_data !== 8'(av[w] * bv[w]) || rsp_id !== ID_W'(w)) begin
                    errors++;
                    $display("FAIL rand_resp n=%0d valid=%b data=%0d id=%0d required 1 %0d %0d",
                             n, rsp_valid, rsp_data, rsp_id, av[w] * bv[w], w);
                end
                rsp_ready = (waited >= 6) ? 1'b1 : 1'($urandom_range(0, 1));
                waited++;
                step();
            end while (rsp_ready == 1'b0);
            checks++;
            if (rsp_valid !== 1'b0) begin
                errors++;
                $display("FAIL rand_done n=%0d valid=%b required 0", n, rsp_valid);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_all_four();
        test_wrap();
        test_backpressure();
        test_reset_mid();
        test_zero();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
